// File: rtl/hangy_input_conditioner_if.sv
// Bus from the input conditioner to the hangman game core: {next, char[4:0]}
// plus status flags. The conditioner drives it through the master modport.
interface hangy_input_conditioner_if;
   logic [5:0] chip_input;
   logic       char_err;
   logic       btn_level;

   modport master (output chip_input, output char_err, output btn_level);
   modport slave  (input  chip_input, input  char_err, input  btn_level);
endinterface

// File: rtl/hangy_input_conditioner.sv
// Synchronises and debounces the board button and letter switches, producing a one-cycle
// "next" pulse with the captured letter. Optional auto-repeat: define HANGY_INPUT_REPEAT_EN.
module hangy_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8,
   parameter int MAX_CHAR        = 25,
   parameter int REPEAT_CYCLES   = 200
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       btn_raw,
   input  logic [4:0]                 char_raw,
   hangy_input_conditioner_if.master  core_bus
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_HIGH = 2'd1;
   localparam logic [1:0] PRESSED   = 2'd2;
   localparam logic [1:0] WAIT_LOW  = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef HANGY_INPUT_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range for CNT_W");
   end
   if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_repeat
      $error("REPEAT_CYCLES out of range for CNT_W");
   end
   if (MAX_CHAR < 0 || MAX_CHAR > 31) begin : g_bad_max_char
      $error("MAX_CHAR must fit the 5-bit letter code");
   end

   logic             btn_m, btn_s;
   logic [4:0]       char_m, char_s;
   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept;
   logic             char_ok;
   logic [5:0]       chip_input;
   logic             char_err;
   logic             btn_level;

   assign char_ok = (char_s <= 5'(MAX_CHAR));

   // Counter is cleared on every state change so it never needs to wrap.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = WAIT_HIGH;
               cnt_nxt   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
               accept    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_nxt = WAIT_LOW;
               cnt_nxt   = '0;
            end
`ifdef HANGY_INPUT_REPEAT_EN
            else if (cnt == REP_LAST) begin
               cnt_nxt = '0;
               accept  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
`endif
         end
         WAIT_LOW: begin
            if (btn_s) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_m      <= 1'b0;
         btn_s      <= 1'b0;
         char_m     <= '0;
         char_s     <= '0;
         state      <= IDLE;
         cnt        <= '0;
         chip_input <= '0;
         char_err   <= 1'b0;
         btn_level  <= 1'b0;
      end else begin
         btn_m     <= btn_raw;
         btn_s     <= btn_m;
         char_m    <= char_raw;
         char_s    <= char_m;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         btn_level <= (state_nxt == PRESSED) || (state_nxt == WAIT_LOW);
         chip_input[5] <= accept && char_ok;
         if (accept && char_ok) begin
            chip_input[4:0] <= char_s;
         end
         if (accept) begin
            char_err <= !char_ok;
         end
      end
   end

   assign core_bus.chip_input = chip_input;
   assign core_bus.char_err   = char_err;
   assign core_bus.btn_level  = btn_level;

endmodule
